// File: rtl/address_map.sv
// Registered, run-time-reconfigurable PET address decoder.
// A page table holds a 3-bit attribute {mirrored, readonly, ram_en} per page; a fixed 256-byte
// I/O window overrides the table. Writes that hit read-only RAM pages are blocked and counted.
module address_map #(
    parameter int unsigned           ADDR_WIDTH     = 17,
    parameter int unsigned           PAGE_BITS      = 5,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE        = 17'h0E800,
    parameter int unsigned           WP_COUNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      we,
    input  logic                      addr_valid,
    input  logic                      cfg_we,
    input  logic [PAGE_BITS-1:0]      cfg_page,
    input  logic [2:0]                cfg_attr,
    input  logic                      cfg_lock,
    input  logic                      wp_clear,
    output logic                      decode_valid,
    output logic                      ram_enable,
    output logic                      ram_we,
    output logic                      is_readonly,
    output logic                      is_mirrored,
    output logic                      io_enable,
    output logic                      magic_enable,
    output logic                      pia1_enable,
    output logic                      pia2_enable,
    output logic                      via_enable,
    output logic                      crtc_enable,
    output logic                      wp_violation,
    output logic [WP_COUNT_WIDTH-1:0] wp_count,
    output logic                      cfg_locked
);

    localparam int unsigned NumPages = 1 << PAGE_BITS;

    // Default map keyed on the page's lowest address, so pages wider than 4 KB inherit the
    // attribute of their base.
    function automatic logic [2:0] default_attr(input int unsigned page);
        int unsigned base;
        base = page << (ADDR_WIDTH - PAGE_BITS);
        if (base < 32'h8000) begin
            return 3'b001;
        end else if (base < 32'h9000) begin
            return 3'b101;
        end else begin
            return 3'b011;
        end
    endfunction

    logic [2:0] table_q [NumPages];
    logic       locked_q;

    logic [PAGE_BITS-1:0] page_idx;
    logic [2:0]           page_attr;
    logic                 in_io;
    logic [7:0]           io_off;

    logic ram_en_d, ro_d, mir_d, ram_we_d, viol_d;
    logic magic_d, pia1_d, pia2_d, via_d, crtc_d, io_d;
    logic [WP_COUNT_WIDTH-1:0] count_d;

    logic decode_valid_q, ram_en_q, ram_we_q, ro_q, mir_q, io_q;
    logic magic_q, pia1_q, pia2_q, via_q, crtc_q, viol_q;
    logic [WP_COUNT_WIDTH-1:0] count_q;

    assign page_idx  = addr[ADDR_WIDTH-1 -: PAGE_BITS];
    // Table read uses the pre-edge contents, so a same-edge config write is not seen yet.
    assign page_attr = table_q[page_idx];
    assign in_io     = (addr[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8]);
    assign io_off    = addr[7:0];

    // Decode one bus cycle: I/O window overrides the page attribute.
    always_comb begin
        ram_en_d = 1'b0;
        ro_d     = 1'b0;
        mir_d    = 1'b0;
        magic_d  = 1'b0;
        pia1_d   = 1'b0;
        pia2_d   = 1'b0;
        via_d    = 1'b0;
        crtc_d   = 1'b0;
        if (addr_valid) begin
            if (in_io) begin
                magic_d = (io_off[7:4] == 4'h0);
                pia1_d  = (io_off[7:4] == 4'h1);
                pia2_d  = (io_off[7:5] == 3'b001);
                via_d   = (io_off[7:6] == 2'b01);
                crtc_d  = io_off[7];
            end else begin
                ram_en_d = page_attr[0];
                ro_d     = page_attr[1];
                mir_d    = page_attr[2];
            end
        end
        // MAGIC is a board-level register, not a bus I/O chip.
        io_d     = pia1_d | pia2_d | via_d | crtc_d;
        ram_we_d = ram_en_d & we & ~ro_d;
        viol_d   = ram_en_d & we & ro_d;
    end

    // Saturating violation counter; a clear coinciding with a violation leaves 1.
    always_comb begin
        count_d = count_q;
        if (wp_clear) begin
            count_d = viol_d ? WP_COUNT_WIDTH'(1) : '0;
        end else if (viol_d && (count_q != '1)) begin
            count_d = count_q + WP_COUNT_WIDTH'(1);
        end
    end

    // Page table and lock: reset reloads defaults; writes ignored once locked.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NumPages; i++) begin
                table_q[i] <= default_attr(i);
            end
            locked_q <= 1'b0;
        end else begin
            if (cfg_we && !locked_q) begin
                table_q[cfg_page] <= cfg_attr;
            end
            if (cfg_lock) begin
                locked_q <= 1'b1;
            end
        end
    end

    // Output register stage: one cycle of latency from addr/we to every decode output.
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_valid_q <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ro_q           <= 1'b0;
            mir_q          <= 1'b0;
            io_q           <= 1'b0;
            magic_q        <= 1'b0;
            pia1_q         <= 1'b0;
            pia2_q         <= 1'b0;
            via_q          <= 1'b0;
            crtc_q         <= 1'b0;
            viol_q         <= 1'b0;
            count_q        <= '0;
        end else begin
            decode_valid_q <= addr_valid;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ro_q           <= ro_d;
            mir_q          <= mir_d;
            io_q           <= io_d;
            magic_q        <= magic_d;
            pia1_q         <= pia1_d;
            pia2_q         <= pia2_d;
            via_q          <= via_d;
            crtc_q         <= crtc_d;
            viol_q         <= viol_d;
            count_q        <= count_d;
        end
    end

    assign decode_valid = decode_valid_q;
    assign ram_enable   = ram_en_q;
    assign ram_we       = ram_we_q;
    assign is_readonly  = ro_q;
    assign is_mirrored  = mir_q;
    assign io_enable    = io_q;
    assign magic_enable = magic_q;
    assign pia1_enable  = pia1_q;
    assign pia2_enable  = pia2_q;
    assign via_enable   = via_q;
    assign crtc_enable  = crtc_q;
    assign wp_violation = viol_q;
    assign wp_count     = count_q;
    assign cfg_locked   = locked_q;

endmodule

// File: tb/tb_address_map.sv
// Bench for address_map: table of decode vectors plus hand-written config/lock/counter
// sequences. Expectations are queued at drive time and compared one cycle later.
module tb_address_map;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] addr;
    logic        we, addr_valid, cfg_we, cfg_lock, wp_clear;
    logic [4:0]  cfg_page;
    logic [2:0]  cfg_attr;
    logic        decode_valid, ram_enable, ram_we, is_readonly, is_mirrored, io_enable;
    logic        magic_enable, pia1_enable, pia2_enable, via_enable, crtc_enable;
    logic        wp_violation, cfg_locked;
    logic [7:0]  wp_count;

    address_map dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .we           (we),
        .addr_valid   (addr_valid),
        .cfg_we       (cfg_we),
        .cfg_page     (cfg_page),
        .cfg_attr     (cfg_attr),
        .cfg_lock     (cfg_lock),
        .wp_clear     (wp_clear),
        .decode_valid (decode_valid),
        .ram_enable   (ram_enable),
        .ram_we       (ram_we),
        .is_readonly  (is_readonly),
        .is_mirrored  (is_mirrored),
        .io_enable    (io_enable),
        .magic_enable (magic_enable),
        .pia1_enable  (pia1_enable),
        .pia2_enable  (pia2_enable),
        .via_enable   (via_enable),
        .crtc_enable  (crtc_enable),
        .wp_violation (wp_violation),
        .wp_count     (wp_count),
        .cfg_locked   (cfg_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0]     exp;
        logic [8*12-1:0] name;
    } sb_t;

    typedef struct {
        logic [16:0] addr;
        logic        we;
        logic        valid;
        logic [20:0] exp;
    } vec_t;

    sb_t  sb [$];
    vec_t vecs [19];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // {valid, ram_en, ro, mir, ram_we, viol, io, magic, pia1, pia2, via, crtc, locked, count}
    function automatic logic [20:0] ex(input logic v, input logic [2:0] attr,
                                       input logic [4:0] dev, input logic io, input logic rw,
                                       input logic viol, input logic lk, input logic [7:0] cnt);
        return {v, attr[0], attr[1], attr[2], rw, viol, io,
                dev[0], dev[1], dev[2], dev[3], dev[4], lk, cnt};
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next
    // rising edge.
    task automatic drive(input logic rst, input logic [16:0] a, input logic w, input logic v,
                         input logic cwe, input logic [4:0] cp, input logic [2:0] ca,
                         input logic lck, input logic clr, input logic [20:0] e,
                         input logic [8*12-1:0] nm);
        sb_t s;
        @(negedge clk);
        reset = rst; addr = a; we = w; addr_valid = v;
        cfg_we = cwe; cfg_page = cp; cfg_attr = ca; cfg_lock = lck; wp_clear = clr;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
    endtask

    task automatic bus(input logic [16:0] a, input logic w, input logic [20:0] e,
                       input logic [8*12-1:0] nm);
        drive(1'b0, a, w, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, e, nm);
    endtask

    // Checker: compare #1 after each rising edge against the oldest queued expectation.
    initial begin
        sb_t         s;
        logic [20:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                s   = sb.pop_front();
                act = {decode_valid, ram_enable, is_readonly, is_mirrored, ram_we, wp_violation,
                       io_enable, magic_enable, pia1_enable, pia2_enable, via_enable,
                       crtc_enable, cfg_locked, wp_count};
                n_cmp++;
                if (act !== s.exp) begin
                    n_fail++;
                    $display("FAIL %0s: got %h want %h", s.name, act, s.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; addr = '0; we = 1'b0; addr_valid = 1'b0;
        cfg_we = 1'b0; cfg_page = '0; cfg_attr = '0; cfg_lock = 1'b0; wp_clear = 1'b0;

        vecs[0]  = '{17'h00000, 1'b0, 1'b1, ex(1, 3'b001, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[1]  = '{17'h07FFF, 1'b0, 1'b1, ex(1, 3'b001, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[2]  = '{17'h08000, 1'b0, 1'b1, ex(1, 3'b101, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[3]  = '{17'h08FFF, 1'b0, 1'b1, ex(1, 3'b101, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[4]  = '{17'h09000, 1'b0, 1'b1, ex(1, 3'b011, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[5]  = '{17'h1FFFF, 1'b0, 1'b1, ex(1, 3'b011, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[6]  = '{17'h0E800, 1'b0, 1'b1, ex(1, 3'b000, 5'b00001, 0, 0, 0, 0, 8'd0)};
        vecs[7]  = '{17'h0E80F, 1'b0, 1'b1, ex(1, 3'b000, 5'b00001, 0, 0, 0, 0, 8'd0)};
        vecs[8]  = '{17'h0E810, 1'b0, 1'b1, ex(1, 3'b000, 5'b00010, 1, 0, 0, 0, 8'd0)};
        vecs[9]  = '{17'h0E820, 1'b0, 1'b1, ex(1, 3'b000, 5'b00100, 1, 0, 0, 0, 8'd0)};
        vecs[10] = '{17'h0E83F, 1'b0, 1'b1, ex(1, 3'b000, 5'b00100, 1, 0, 0, 0, 8'd0)};
        vecs[11] = '{17'h0E840, 1'b0, 1'b1, ex(1, 3'b000, 5'b01000, 1, 0, 0, 0, 8'd0)};
        vecs[12] = '{17'h0E880, 1'b0, 1'b1, ex(1, 3'b000, 5'b10000, 1, 0, 0, 0, 8'd0)};
        vecs[13] = '{17'h0E8FF, 1'b0, 1'b1, ex(1, 3'b000, 5'b10000, 1, 0, 0, 0, 8'd0)};
        vecs[14] = '{17'h0E900, 1'b0, 1'b1, ex(1, 3'b011, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[15] = '{17'h0E810, 1'b0, 1'b0, ex(0, 3'b000, 5'b00000, 0, 0, 0, 0, 8'd0)};
        vecs[16] = '{17'h01234, 1'b1, 1'b1, ex(1, 3'b001, 5'b00000, 0, 1, 0, 0, 8'd0)};
        vecs[17] = '{17'h0E810, 1'b1, 1'b1, ex(1, 3'b000, 5'b00010, 1, 0, 0, 0, 8'd0)};
        vecs[18] = '{17'h0F000, 1'b0, 1'b1, ex(1, 3'b011, 5'b00000, 0, 0, 0, 0, 8'd0)};

        repeat (2) @(negedge clk);
        // Reset has priority over a live write.
        drive(1, 17'h0C000, 1, 1, 0, 5'd0, 3'd0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 8'd0), "reset");

        for (int i = 0; i < 19; i++) begin
            drive(0, vecs[i].addr, vecs[i].we, vecs[i].valid, 0, 5'd0, 3'd0, 0, 0,
                  vecs[i].exp, "vec");
        end

        // Blocked write to ROM, then the pulse drops.
        bus(17'h0C000, 1, ex(1, 3'b011, 0, 0, 0, 1, 0, 8'd1), "wp_first");
        drive(0, 17'h0C000, 1, 0, 0, 5'd0, 3'd0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 8'd1), "wp_pulse");

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            cnt = (i + 2 > 255) ? 255 : i + 2;
            bus(17'h0C000, 1, ex(1, 3'b011, 0, 0, 0, 1, 0, cnt[7:0]), "wp_sat");
        end
        drive(0, 17'h0C000, 1, 1, 0, 5'd0, 3'd0, 0, 1, ex(1, 3'b011, 0, 0, 0, 1, 0, 8'd1),
              "clr_viol");
        drive(0, 17'h00000, 0, 0, 0, 5'd0, 3'd0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 8'd0), "clr");

        // Same-edge table write is not seen by the decode; next cycle is.
        drive(0, 17'h0C123, 1, 1, 1, 5'h0C, 3'b001, 0, 0, ex(1, 3'b011, 0, 0, 0, 1, 0, 8'd1),
              "rbw_old");
        bus(17'h0C123, 1, ex(1, 3'b001, 0, 0, 1, 0, 0, 8'd1), "rbw_new");

        // Lock: same-edge write to page 0x0D commits, later writes are ignored.
        drive(0, 17'h00000, 0, 1, 1, 5'h0D, 3'b001, 1, 0, ex(1, 3'b001, 0, 0, 0, 0, 1, 8'd1),
              "lock");
        drive(0, 17'h00000, 0, 1, 1, 5'h00, 3'b011, 0, 0, ex(1, 3'b001, 0, 0, 0, 0, 1, 8'd1),
              "lock_wr");
        bus(17'h00000, 0, ex(1, 3'b001, 0, 0, 0, 0, 1, 8'd1), "lock_hold");
        bus(17'h0D000, 1, ex(1, 3'b001, 0, 0, 1, 0, 1, 8'd1), "lock_edge");

        // Mid-stream reset restores defaults, clears lock and count.
        drive(1, 17'h0C000, 1, 1, 1, 5'h0C, 3'b001, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 8'd0),
              "rst_mid");
        bus(17'h0C000, 0, ex(1, 3'b011, 0, 0, 0, 0, 0, 8'd0), "rst_dflt_c");
        bus(17'h0D000, 1, ex(1, 3'b011, 0, 0, 0, 1, 0, 8'd1), "rst_dflt_d");
        drive(0, 17'h00000, 0, 1, 1, 5'h00, 3'b101, 0, 0, ex(1, 3'b001, 0, 0, 0, 0, 0, 8'd1),
              "unlock_old");
        bus(17'h00000, 0, ex(1, 3'b101, 0, 0, 0, 0, 0, 8'd1), "unlock_new");

        @(negedge clk);
        addr_valid = 1'b0; we = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0; wp_clear = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/address_map.md
Name: address_map

Overview:
- Registered, run-time-reconfigurable successor to the fixed PET address decoder.
- Splits the address space into 2^PAGE_BITS pages, each with a programmable 3-bit attribute (RAM enable, read-only, mirrored), held in an internal page table.
- Overlays a fixed 256-byte PET I/O window (MAGIC/PIA1/PIA2/VIA/CRTC) and gates RAM writes to read-only pages.
- Counts blocked writes; sits between the bus arbiter and the RAM/IO chip-select logic.

Parameters:
- ADDR_WIDTH, 17, bus address width.
- PAGE_BITS, 5, number of page-index bits; page index = addr[ADDR_WIDTH-1 -: PAGE_BITS], page size 2^(ADDR_WIDTH-PAGE_BITS).
- IO_BASE, 17'h0E800, base of the 256-byte I/O window; must be 256-aligned.
- WP_COUNT_WIDTH, 8, width of the saturating write-protect violation counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  bus address
- we  in  1  bus write strobe qualifier, 1 = write
- addr_valid  in  1  addr/we valid this cycle
- cfg_we  in  1  page-table write strobe
- cfg_page  in  PAGE_BITS  page-table index to write
- cfg_attr  in  3  {mirrored, readonly, ram_en}
- cfg_lock  in  1  pulse: freeze page table until reset
- wp_clear  in  1  clear violation counter
- decode_valid  out  1  outputs below are valid
- ram_enable  out  1  page is RAM-backed
- ram_we  out  1  write permitted to RAM
- is_readonly  out  1  page read-only
- is_mirrored  out  1  page mirrored (VRAM)
- io_enable  out  1  any I/O device selected
- magic_enable  out  1  E800-E80F
- pia1_enable  out  1  E810-E81F
- pia2_enable  out  1  E820-E83F
- via_enable  out  1  E840-E87F
- crtc_enable  out  1  E880-E8FF
- wp_violation  out  1  one-cycle pulse on a blocked write
- wp_count  out  WP_COUNT_WIDTH  saturating count of blocked writes
- cfg_locked  out  1  page table frozen

Behaviour:
- Reset (sync, priority over all): every output 0; cfg_locked = 0.
- Reset reloads the default map, using page base address B:
  - B < 0x8000: 3'b001 (RAM)
  - 0x8000 <= B < 0x9000: 3'b101 (VRAM)
  - all other pages, including addr[16] = 1: 3'b011 (ROM)
- Reset load takes one cycle. Pages coarser than 4 KB take the attribute of their lowest address.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N; decode_valid = registered addr_valid.
- When addr_valid = 0, all enables and wp_violation register 0 on the next edge.
- I/O window (addr[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8]):
  - ram_enable, is_readonly, is_mirrored are forced 0; the page attribute is ignored.
  - Exactly one device enable is set per the ranges above; io_enable = OR of pia1/pia2/via/crtc.
  - MAGIC does not assert io_enable.
- Outside the window: ram_enable/is_readonly/is_mirrored = page attribute; all I/O enables 0.
- ram_we = ram_enable & we & ~is_readonly.
- wp_violation = ram_enable & we & is_readonly.
- wp_count:
  - increments on each wp_violation and saturates at all-ones.
  - wp_clear resets it to 0 on the next edge.
  - wp_clear together with a violation on the same edge gives 1.
- Page-table write: on cfg_we & ~cfg_locked, entry cfg_page <= cfg_attr at the edge.
  - A decode sampled on the same edge for the same page uses the OLD attribute (read-before-write); the next cycle sees the new one.
- Lock: cfg_lock sets cfg_locked on the edge. A cfg_we on the same edge as cfg_lock still commits. Afterwards cfg_we is ignored until reset.
- Reset asserted mid-stream: outputs 0 on the following cycle; table restored to defaults; lock and count cleared.

Test Plan:
- After reset, decode 0x0000, 0x7FFF, 0x8000, 0x8FFF, 0x9000, 0x1FFFF -> attrs 001, 001, 101, 101, 011, 011, each one cycle after input with decode_valid = 1.
- I/O sweep E800, E80F, E810, E820, E83F, E840, E880, E8FF, E900 -> magic, magic, pia1, pia2, pia2, via, crtc, crtc, then ROM (011); io_enable 0 for magic and ROM, 1 for the others.
- Write to 0xC000 (ROM) -> ram_we = 0, wp_violation pulse, wp_count = 1. Issue 300 such writes -> wp_count = 255. wp_clear concurrent with a violation -> wp_count = 1.
- cfg_we page 0x0C attr 001 on the same cycle as a write to 0xC123 -> that write is blocked. Repeat the write next cycle -> ram_we = 1, no violation.
- cfg_lock, then cfg_we page 0 attr 011 -> 0x0000 still decodes as 001 and cfg_locked = 1. Assert reset -> cfg_locked = 0, defaults restored.
- addr_valid = 0 with addr = 0xE810 -> all enables 0 and decode_valid = 0 next cycle.
